// File: rtl/exc_entry.sv
// -----------------------------------------------------------------------------
// exc_entry -- exception-entry controller (counterpart of the eret path).
//
// Samples the commit-stage request and the interrupt lines while idle, picks
// the highest-priority cause, and then:
//   * pulses flush + cp0_wr for one cycle. cp0_wr applies EPC/BD, ExcCode and
//     BadVAddr, and sets Status.EXL.
//   * holds redir_valid/redir_pc toward fetch until fetch_ready.
//
// Optional feature macro: EXC_TIMER_EN
//   Defined   -> Count/Compare timer. Count runs at clk/2, and timer_int drives IP7.
//   Undefined -> no timer. count_o = compare_o = 0 and IP7 = hw_int[5].
//
// Ports
//   clk, rst              core clock, asynchronous active-high reset
//   req_valid             commit-stage instruction valid
//   req_exc[5:0]          {adel_if, ri, sys, bp, ov, ades_mem}
//   req_pc, req_bd        PC of the committing instruction, delay-slot flag
//   req_badaddr           faulting address for AdEL/AdES
//   hw_int[5:0]           level-sensitive interrupt lines IP2..IP7
//   st_ie/st_exl/st_bev   Status bits; st_im[7:0] = Status.IM
//   count_wr/compare_wr   mtc0 writes to Count/Compare, data on wr_data
//   fetch_ready           fetch accepts the redirect this cycle
//   flush                 one-cycle kill of all in-flight instructions
//   redir_valid/redir_pc  redirect request to the exception vector
//   cp0_wr                one-cycle CP0 update strobe
//   epc_wr, epc_o, cause_bd_o     EPC/BD update (suppressed when EXL already set)
//   cause_exc_o           ExcCode
//   badvaddr_wr, badvaddr_o       BadVAddr update (AdEL/AdES only)
//   cause_ip_o            live Cause.IP bits
//   count_o, compare_o    timer registers for mfc0
// -----------------------------------------------------------------------------
module exc_entry #(
  parameter logic [31:0] RESET_VEC  = 32'hBFC0_0380,
  parameter logic [31:0] NORMAL_VEC = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  req_exc,
  input  logic [31:0] req_pc,
  input  logic        req_bd,
  input  logic [31:0] req_badaddr,
  input  logic [5:0]  hw_int,
  input  logic        st_ie,
  input  logic        st_exl,
  input  logic        st_bev,
  input  logic [7:0]  st_im,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  input  logic        fetch_ready,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        cp0_wr,
  output logic        epc_wr,
  output logic [31:0] epc_o,
  output logic [4:0]  cause_exc_o,
  output logic        cause_bd_o,
  output logic        badvaddr_wr,
  output logic [31:0] badvaddr_o,
  output logic [7:0]  cause_ip_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o
);

  // MIPS ExcCode values.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions inside req_exc.
  localparam int B_ADEL = 5;
  localparam int B_RI   = 4;
  localparam int B_SYS  = 3;
  localparam int B_BP   = 2;
  localparam int B_OV   = 1;
  localparam int B_ADES = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAKE,
    S_REDIR
  } state_t;

  state_t state_q, state_d;
  logic   timer_int;

  // ---------------------------------------------------------------------------
  // Count/Compare timer
  // ---------------------------------------------------------------------------
`ifdef EXC_TIMER_EN
  logic        half_q;     // high on the edges that advance Count
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_q;
  logic        inc;

  // An mtc0 to Count replaces the increment on that edge.
  assign inc = half_q & ~count_wr;

  // NOTE: every sequential block uses non-blocking (<=) assignments so that
  // all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      half_q <= ~half_q;

      if (count_wr)
        count_q <= wr_data;
      else if (half_q)
        count_q <= count_q + 32'd1;   // wraps naturally at 2^32

      if (compare_wr)
        compare_q <= wr_data;

      // The match is sticky until software rewrites Compare.
      if (compare_wr)
        timer_q <= 1'b0;
      else if (inc && (count_q == compare_q))
        timer_q <= 1'b1;
    end
  end

  assign timer_int = timer_q;
  assign count_o   = count_q;
  assign compare_o = compare_q;
`else
  // The mtc0 timer inputs have no function without the timer.
  logic unused_timer_inputs;
  assign unused_timer_inputs = ^{count_wr, compare_wr, wr_data};

  assign timer_int = 1'b0;
  assign count_o   = '0;
  assign compare_o = '0;
`endif

  // ---------------------------------------------------------------------------
  // Interrupt pending and candidate detection
  // ---------------------------------------------------------------------------
  logic int_pend;
  logic candidate;

  assign cause_ip_o = {hw_int[5] | timer_int, hw_int[4:0], 2'b00};
  assign int_pend   = (|(cause_ip_o & st_im)) & st_ie & ~st_exl;
  assign candidate  = req_valid & (int_pend | (|req_exc));

  // ---------------------------------------------------------------------------
  // Priority selection: Int > AdEL > RI > Sys > Bp > Ov > AdES
  // ---------------------------------------------------------------------------
  logic [4:0] sel_code;
  logic       sel_ade;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sel_code = EXC_INT;
    sel_ade  = 1'b0;
    if (int_pend) begin
      sel_code = EXC_INT;
    end else if (req_exc[B_ADEL]) begin
      sel_code = EXC_ADEL;
      sel_ade  = 1'b1;
    end else if (req_exc[B_RI]) begin
      sel_code = EXC_RI;
    end else if (req_exc[B_SYS]) begin
      sel_code = EXC_SYS;
    end else if (req_exc[B_BP]) begin
      sel_code = EXC_BP;
    end else if (req_exc[B_OV]) begin
      sel_code = EXC_OV;
    end else if (req_exc[B_ADES]) begin
      sel_code = EXC_ADES;
      sel_ade  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (candidate) state_d = S_TAKE;
      S_TAKE:  state_d = S_REDIR;
      S_REDIR: if (fetch_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode directly from the state register. They are glitch-free
  // per state and drop the moment reset asserts.
  assign flush       = (state_q == S_TAKE);
  assign cp0_wr      = (state_q == S_TAKE);
  assign redir_valid = (state_q == S_REDIR);

  // ---------------------------------------------------------------------------
  // Entry payload, captured only at the IDLE->TAKE edge. It stays stable
  // through TAKE and REDIR, because req_* is ignored outside IDLE.
  // ---------------------------------------------------------------------------
  logic take_now;
  assign take_now = (state_q == S_IDLE) & candidate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_pc    <= RESET_VEC;
      epc_wr      <= 1'b0;
      epc_o       <= '0;
      cause_bd_o  <= 1'b0;
      cause_exc_o <= '0;
      badvaddr_wr <= 1'b0;
      badvaddr_o  <= '0;
    end else if (take_now) begin
      redir_pc    <= st_bev ? RESET_VEC : NORMAL_VEC;
      cause_exc_o <= sel_code;
      epc_wr      <= ~st_exl;
      badvaddr_wr <= sel_ade;
      if (sel_ade)
        badvaddr_o <= req_badaddr;
      // A nested entry (EXL already set) keeps the original EPC/BD.
      if (!st_exl) begin
        epc_o      <= req_bd ? (req_pc - 32'd4) : req_pc;
        cause_bd_o <= req_bd;
      end
    end
  end

endmodule
